// File: rtl/lcd_seq_pkg.sv
// Shared types and defaults for the LCD bus sequencer.
// LCD_SEQ_BUSY_POLL_EN adds the busy-flag poll states to the state enum.
package lcd_seq_pkg;

    localparam int DEF_T_AS = 3;
    localparam int DEF_T_PW = 12;
    localparam int DEF_T_H  = 10;

    localparam int ADDR_RW = 0;
    localparam int ADDR_RS = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_DONE
`ifdef LCD_SEQ_BUSY_POLL_EN
        ,
        S_POLL_SETUP,
        S_POLL_EHIGH,
        S_POLL_HOLD
`endif
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_seq_phase_timer.sv
// Loadable down-counter shared by every timed phase; saturates at zero.
module lcd_seq_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Avalon-MM slave turning bus accesses into timed HD44780 cycles.
// Define LCD_SEQ_BUSY_POLL_EN to poll the busy flag after every write.
module lcd_bus_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int T_AS = DEF_T_AS,
    parameter int T_PW = DEF_T_PW,
    parameter int T_H  = DEF_T_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam int CW = $clog2(max3(T_AS, T_PW, T_H)) + 1;
    localparam logic [CW-1:0] LD_AS = CW'(T_AS - 1);
    localparam logic [CW-1:0] LD_PW = CW'(T_PW - 1);
    localparam logic [CW-1:0] LD_H  = CW'(T_H - 1);

    state_e     state_q, state_d;
    logic       rs_q, rs_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
`ifdef LCD_SEQ_BUSY_POLL_EN
    logic       busy_q, busy_d;
`endif

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    lcd_seq_phase_timer #(.W(CW)) u_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rs_q    <= 1'b0;
            rw_q    <= 1'b1;
            oe_q    <= 1'b0;
            is_wr_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LCD_SEQ_BUSY_POLL_EN
            busy_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            is_wr_q <= is_wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef LCD_SEQ_BUSY_POLL_EN
            busy_q  <= busy_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        rw_d     = rw_q;
        oe_d     = oe_q;
        is_wr_d  = is_wr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef LCD_SEQ_BUSY_POLL_EN
        busy_d   = busy_q;
`endif
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            S_IDLE: begin
                if (read | write) begin
                    state_d  = S_SETUP;
                    rs_d     = address[ADDR_RS];
                    rw_d     = address[ADDR_RW];
                    is_wr_d  = write;
                    wdata_d  = writedata;
                    oe_d     = write & ~address[ADDR_RW];
                    tmr_load = 1'b1;
                    tmr_val  = LD_AS;
                end
            end
            S_SETUP: begin
                if (tmr_zero) begin
                    state_d  = S_EHIGH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_PW;
                end
            end
            S_EHIGH: begin
                if (tmr_zero) begin
                    if (!is_wr_q) begin
                        rdata_d = LCD_data;
                    end
                    state_d  = S_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_H;
                end
            end
            S_HOLD: begin
                if (tmr_zero) begin
`ifdef LCD_SEQ_BUSY_POLL_EN
                    if (is_wr_q) begin
                        // switch the pins over to a status read for the poll
                        state_d  = S_POLL_SETUP;
                        rs_d     = 1'b0;
                        rw_d     = 1'b1;
                        oe_d     = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = LD_AS;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rs_d    = 1'b0;
                rw_d    = 1'b1;
                oe_d    = 1'b0;
            end
`ifdef LCD_SEQ_BUSY_POLL_EN
            S_POLL_SETUP: begin
                if (tmr_zero) begin
                    state_d  = S_POLL_EHIGH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_PW;
                end
            end
            S_POLL_EHIGH: begin
                if (tmr_zero) begin
                    busy_d   = LCD_data[7];
                    state_d  = S_POLL_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_H;
                end
            end
            S_POLL_HOLD: begin
                if (tmr_zero) begin
                    if (busy_q) begin
                        state_d  = S_POLL_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = LD_AS;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        LCD_E = (state_q == S_EHIGH);
`ifdef LCD_SEQ_BUSY_POLL_EN
        if (state_q == S_POLL_EHIGH) begin
            LCD_E = 1'b1;
        end
`endif
    end

    assign LCD_RS      = rs_q;
    assign LCD_RW      = rw_q;
    assign LCD_data    = oe_q ? wdata_q : 'z;
    assign readdata    = rdata_q;
    assign waitrequest = (read | write) & (state_q != S_DONE);

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with a small LCD pin model.
// LCD_SEQ_BUSY_POLL_EN selects the busy-poll scenario instead of the plain ones.
module tb_lcd_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       waitrequest;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    wire  [7:0] LCD_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cycnt = 0;

    logic [7:0] rd_val    = 8'h00;
    int         busy_cnt  = 0;
    logic       probe_en  = 1'b0;
    logic [7:0] probe_val = 8'h00;
    logic [7:0] lcd_drv;

    always #5 clk = ~clk;
    always @(posedge clk) cycnt <= cycnt + 1;

    // LCD model: drives the bus while E is high on a read; RS=0 returns the busy flag
    assign lcd_drv  = LCD_RS ? rd_val : {(busy_cnt != 0), 7'h00};
    assign LCD_data = probe_en ? probe_val : ((LCD_E && LCD_RW) ? lcd_drv : 8'hzz);

    always @(negedge LCD_E) begin
        if (!LCD_RS && LCD_RW && busy_cnt > 0) busy_cnt = busy_cnt - 1;
    end

    lcd_bus_sequencer #(.T_AS(3), .T_PW(12), .T_H(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .LCD_E       (LCD_E),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_data    (LCD_data)
    );

    // Released bus reads back both complementary probe patterns untouched.
    task automatic probe_bus(output bit released);
        bit r1, r2;
        probe_en  = 1'b1;
        probe_val = 8'hC3;
        #1 r1 = (LCD_data === 8'hC3);
        probe_val = 8'h3C;
        #1 r2 = (LCD_data === 8'h3C);
        probe_en = 1'b0;
        released = r1 && r2;
    endtask

    // One bus transaction with cycle-accurate pin measurements (cycle 0 = request first seen).
    task automatic do_txn(input logic [1:0] a, input logic rd, input logic wr,
                          input logic [7:0] wd, input bit b2b, input bit poke,
                          output int rise, output int fall, output int done,
                          output int nrise, output int rise_abs, output logic [7:0] d1,
                          output logic rs1, output logic rw1, output bit unstable,
                          output logic [7:0] rdat_done);
        int   cyc;
        logic prev_e;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        address = a; read = rd; write = wr; writedata = wd;
        cyc = 0; rise = -1; fall = -1; done = -1; nrise = 0; rise_abs = -1;
        prev_e = 1'b0; unstable = 1'b0; d1 = 8'h00; rs1 = 1'b0; rw1 = 1'b0;
        rdat_done = 8'h00;
        while (done < 0 && cyc < 400) begin
            @(negedge clk);
            if (LCD_E && !prev_e) begin
                nrise++;
                if (rise < 0) begin
                    rise = cyc;
                    rise_abs = cycnt;
                end
            end
            if (!LCD_E && prev_e && fall < 0) fall = cyc;
            prev_e = LCD_E;
            if (cyc == 1) begin
                d1 = LCD_data; rs1 = LCD_RS; rw1 = LCD_RW;
            end else if (cyc > 1) begin
                if (LCD_RS !== rs1 || LCD_RW !== rw1 || (wr && LCD_data !== d1)) unstable = 1'b1;
            end
            if (!waitrequest) begin
                done = cyc;
                rdat_done = readdata;
            end
            if (poke && cyc == 5) begin
                address = ~a;
                writedata = ~wd;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset;
        bit rel;
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 2'b00; writedata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (LCD_E !== 1'b0) begin n_bad++; $display("FAIL rst_E: got %b want 0", LCD_E); end
        n_cmp++; if (LCD_RS !== 1'b0) begin n_bad++; $display("FAIL rst_RS: got %b want 0", LCD_RS); end
        n_cmp++; if (LCD_RW !== 1'b1) begin n_bad++; $display("FAIL rst_RW: got %b want 1", LCD_RW); end
        n_cmp++; if (readdata !== 8'h00) begin n_bad++; $display("FAIL rst_readdata: got %h want 00", readdata); end
        n_cmp++; if (waitrequest !== 1'b0) begin n_bad++; $display("FAIL rst_wait: got %b want 0", waitrequest); end
        probe_bus(rel);
        n_cmp++; if (rel !== 1'b1) begin n_bad++; $display("FAIL rst_busz: got %b want 1", rel); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_write;
        int r, f, d, n, ra; logic [7:0] d1, rdd; logic rs1, rw1; bit un, rel;
        do_txn(2'b00, 1'b0, 1'b1, 8'h38, 1'b0, 1'b0, r, f, d, n, ra, d1, rs1, rw1, un, rdd);
        n_cmp++; if (r !== 4)  begin n_bad++; $display("FAIL wr_rise: got %0d want 4", r); end
        n_cmp++; if (f !== 16) begin n_bad++; $display("FAIL wr_fall: got %0d want 16", f); end
        n_cmp++; if (d !== 26) begin n_bad++; $display("FAIL wr_done: got %0d want 26", d); end
        n_cmp++; if (d1 !== 8'h38) begin n_bad++; $display("FAIL wr_data: got %h want 38", d1); end
        n_cmp++; if (rs1 !== 1'b0) begin n_bad++; $display("FAIL wr_rs: got %b want 0", rs1); end
        n_cmp++; if (rw1 !== 1'b0) begin n_bad++; $display("FAIL wr_rw: got %b want 0", rw1); end
        n_cmp++; if (un !== 1'b0) begin n_bad++; $display("FAIL wr_stable: got %b want 0", un); end
        @(negedge clk);
        n_cmp++; if (LCD_RW !== 1'b1) begin n_bad++; $display("FAIL wr_idle_rw: got %b want 1", LCD_RW); end
        n_cmp++; if (waitrequest !== 1'b0) begin n_bad++; $display("FAIL wr_idle_wait: got %b want 0", waitrequest); end
        probe_bus(rel);
        n_cmp++; if (rel !== 1'b1) begin n_bad++; $display("FAIL wr_busz: got %b want 1", rel); end
    endtask

    task automatic test_read;
        int r, f, d, n, ra; logic [7:0] d1, rdd; logic rs1, rw1; bit un;
        rd_val = 8'hA5;
        do_txn(2'b11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, r, f, d, n, ra, d1, rs1, rw1, un, rdd);
        n_cmp++; if (d !== 26) begin n_bad++; $display("FAIL rd_done: got %0d want 26", d); end
        n_cmp++; if (rdd !== 8'hA5) begin n_bad++; $display("FAIL rd_data: got %h want a5", rdd); end
        n_cmp++; if (rs1 !== 1'b1 || rw1 !== 1'b1) begin n_bad++; $display("FAIL rd_pins: got rs=%b rw=%b want 1 1", rs1, rw1); end
        rd_val = 8'h5A;
        do_txn(2'b10, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0, r, f, d, n, ra, d1, rs1, rw1, un, rdd);
        n_cmp++; if (readdata !== 8'hA5) begin n_bad++; $display("FAIL rd_hold: got %h want a5", readdata); end
        n_cmp++; if (d1 !== 8'h42 || rs1 !== 1'b1) begin n_bad++; $display("FAIL rd_wrdat: got %h rs=%b want 42 1", d1, rs1); end
    endtask

    task automatic test_both;
        int r, f, d, n, ra; logic [7:0] d1, rdd; logic rs1, rw1; bit un;
        do_txn(2'b00, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, r, f, d, n, ra, d1, rs1, rw1, un, rdd);
        n_cmp++; if (d1 !== 8'h41) begin n_bad++; $display("FAIL both_data: got %h want 41", d1); end
        n_cmp++; if (rw1 !== 1'b0) begin n_bad++; $display("FAIL both_rw: got %b want 0", rw1); end
        n_cmp++; if (d !== 26) begin n_bad++; $display("FAIL both_done: got %0d want 26", d); end
        n_cmp++; if (readdata !== 8'hA5) begin n_bad++; $display("FAIL both_readdata: got %h want a5", readdata); end
    endtask

    task automatic test_back_to_back;
        int r, f, d, n, ra1, ra2; logic [7:0] d1, rdd; logic rs1, rw1; bit un;
        do_txn(2'b00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, r, f, d, n, ra1, d1, rs1, rw1, un, rdd);
        do_txn(2'b10, 1'b0, 1'b1, 8'h48, 1'b1, 1'b1, r, f, d, n, ra2, d1, rs1, rw1, un, rdd);
        n_cmp++; if (ra2 - ra1 !== 27) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 27", ra2 - ra1); end
        n_cmp++; if (d !== 26) begin n_bad++; $display("FAIL b2b_done: got %0d want 26", d); end
        n_cmp++; if (d1 !== 8'h48) begin n_bad++; $display("FAIL b2b_data: got %h want 48", d1); end
        n_cmp++; if (rs1 !== 1'b1 || rw1 !== 1'b0) begin n_bad++; $display("FAIL b2b_pins: got rs=%b rw=%b want 1 0", rs1, rw1); end
        n_cmp++; if (un !== 1'b0) begin n_bad++; $display("FAIL b2b_latch: got %b want 0", un); end
    endtask

    task automatic test_reset_mid;
        int r, f, d, n, ra; logic [7:0] d1, rdd; logic rs1, rw1; bit un, rel, seen;
        @(posedge clk);
        #1 address = 2'b10; write = 1'b1; writedata = 8'h77;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1 seen = LCD_E;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rmid_e_seen: got %b want 1", seen); end
        reset = 1'b1; write = 1'b0;
        #1;
        n_cmp++; if (LCD_E !== 1'b0) begin n_bad++; $display("FAIL rmid_E: got %b want 0", LCD_E); end
        n_cmp++; if (LCD_RW !== 1'b1 || LCD_RS !== 1'b0) begin n_bad++; $display("FAIL rmid_pins: got rw=%b rs=%b want 1 0", LCD_RW, LCD_RS); end
        n_cmp++; if (readdata !== 8'h00) begin n_bad++; $display("FAIL rmid_readdata: got %h want 00", readdata); end
        n_cmp++; if (waitrequest !== 1'b0) begin n_bad++; $display("FAIL rmid_wait: got %b want 0", waitrequest); end
        probe_bus(rel);
        n_cmp++; if (rel !== 1'b1) begin n_bad++; $display("FAIL rmid_busz: got %b want 1", rel); end
        @(posedge clk);
        #1 reset = 1'b0;
        do_txn(2'b00, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, r, f, d, n, ra, d1, rs1, rw1, un, rdd);
        n_cmp++; if (r !== 4 || d !== 26) begin n_bad++; $display("FAIL rmid_next: got rise=%0d done=%0d want 4 26", r, d); end
    endtask

    task automatic test_busy_poll;
        int r, f, d, n, ra; logic [7:0] d1, rdd; logic rs1, rw1; bit un;
        rd_val = 8'hA5;
        do_txn(2'b11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, r, f, d, n, ra, d1, rs1, rw1, un, rdd);
        n_cmp++; if (d !== 26 || rdd !== 8'hA5) begin n_bad++; $display("FAIL poll_read: got done=%0d data=%h want 26 a5", d, rdd); end
        busy_cnt = 2;
        do_txn(2'b00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, r, f, d, n, ra, d1, rs1, rw1, un, rdd);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL poll_pulses: got %0d want 4", n); end
        n_cmp++; if (d !== 101) begin n_bad++; $display("FAIL poll_done: got %0d want 101", d); end
        n_cmp++; if (busy_cnt !== 0) begin n_bad++; $display("FAIL poll_busycnt: got %0d want 0", busy_cnt); end
        n_cmp++; if (readdata !== 8'hA5) begin n_bad++; $display("FAIL poll_readdata: got %h want a5", readdata); end
    endtask

    initial begin
        test_reset;
`ifdef LCD_SEQ_BUSY_POLL_EN
        test_busy_poll;
`else
        test_write;
        test_read;
        test_both;
        test_back_to_back;
        test_reset_mid;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
